// File: rtl/pmu_tick_generator.sv
// Phase-accumulator tick generator: produces cycle-wrap and sample-boundary pulses,
// with phase-continuous frequency updates and a SYNC realignment input.
module pmu_tick_generator #(
   parameter int ACC_WIDTH   = 32,
   parameter int SPC_LOG2    = 6,
   parameter int DEFAULT_INC = 65536
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 ENABLE,
   input  logic                 SYNC,
   input  logic [ACC_WIDTH-1:0] FREQ_WORD,
   input  logic                 FREQ_VALID,
   output logic                 FREQ_READY,
   output logic                 FREQ_ERR,
   output logic                 CYCLE_PULSE,
   output logic                 SAMPLE_PULSE,
   output logic [SPC_LOG2-1:0]  SAMPLE_INDEX,
   output logic [ACC_WIDTH-1:0] PHASE
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } upd_state_t;

   // Largest increment that still advances the sample index by at most one per clock
   localparam logic [ACC_WIDTH-1:0] MAX_INC   = {{SPC_LOG2{1'b0}}, {(ACC_WIDTH-SPC_LOG2){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] RESET_INC = ACC_WIDTH'(DEFAULT_INC);
   localparam logic [ACC_WIDTH-1:0] ZERO_WORD = {ACC_WIDTH{1'b0}};

   upd_state_t           state_r, state_s;
   logic [ACC_WIDTH-1:0] acc_r, acc_s;
   logic [ACC_WIDTH-1:0] inc_r, inc_s;
   logic [ACC_WIDTH-1:0] pend_r, pend_s;
   logic                 cycle_r, cycle_s;
   logic                 sample_r, sample_s;
   logic                 err_r, err_s;
   logic                 ready_r, ready_s;
   logic [ACC_WIDTH:0]   sum_s;
   logic                 accept_s;
   logic                 word_ok_s;

   // Next-state: accumulator, increment, update FSM and pulse outputs
   always_comb begin
      state_s   = state_r;
      acc_s     = acc_r;
      inc_s     = inc_r;
      pend_s    = pend_r;
      cycle_s   = 1'b0;
      sample_s  = 1'b0;
      err_s     = 1'b0;
      sum_s     = {1'b0, acc_r} + {1'b0, inc_r};
      accept_s  = FREQ_VALID && (state_r == IDLE);
      word_ok_s = (FREQ_WORD != ZERO_WORD) && (FREQ_WORD <= MAX_INC);

      if (SYNC) begin
         acc_s    = ZERO_WORD;
         cycle_s  = ENABLE;
         sample_s = ENABLE;
         state_s  = IDLE;
         err_s    = accept_s && !word_ok_s;
         // A word arriving with SYNC wins over an older pending one
         if (accept_s && word_ok_s) begin
            inc_s = FREQ_WORD;
         end else if (state_r == PENDING) begin
            inc_s = pend_r;
         end else begin
            inc_s = inc_r;
         end
      end else begin
         if (ENABLE) begin
            acc_s    = sum_s[ACC_WIDTH-1:0];
            cycle_s  = sum_s[ACC_WIDTH];
            sample_s = sum_s[ACC_WIDTH-1 -: SPC_LOG2] != acc_r[ACC_WIDTH-1 -: SPC_LOG2];
         end else begin
            acc_s = acc_r;
         end

         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  if (word_ok_s) begin
                     pend_s  = FREQ_WORD;
                     state_s = PENDING;
                  end else begin
                     err_s = 1'b1;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
            PENDING: begin
               // Swap increments only at the wrap so the phase stays continuous
               if (ENABLE && sum_s[ACC_WIDTH]) begin
                  inc_s   = pend_r;
                  state_s = IDLE;
               end else begin
                  state_s = PENDING;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end

      ready_s = (state_s == IDLE);
   end

   // State and output registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r  <= IDLE;
         acc_r    <= ZERO_WORD;
         inc_r    <= RESET_INC;
         pend_r   <= ZERO_WORD;
         cycle_r  <= 1'b0;
         sample_r <= 1'b0;
         err_r    <= 1'b0;
         ready_r  <= 1'b1;
      end else begin
         state_r  <= state_s;
         acc_r    <= acc_s;
         inc_r    <= inc_s;
         pend_r   <= pend_s;
         cycle_r  <= cycle_s;
         sample_r <= sample_s;
         err_r    <= err_s;
         ready_r  <= ready_s;
      end
   end

   assign FREQ_READY   = ready_r;
   assign FREQ_ERR     = err_r;
   assign CYCLE_PULSE  = cycle_r;
   assign SAMPLE_PULSE = sample_r;
   assign SAMPLE_INDEX = acc_r[ACC_WIDTH-1 -: SPC_LOG2];
   assign PHASE        = acc_r;

endmodule

// File: tb/tb_pmu_tick_generator.sv
// Scoreboard bench for pmu_tick_generator with an 8-bit accumulator and 4 samples per cycle.
module tb_pmu_tick_generator;

   localparam int W   = 8;
   localparam int S   = 2;
   localparam int DEF = 16;
   localparam int MAX = 63;

   logic         CLK = 1'b0;
   logic         nRST = 1'b0;
   logic         ENABLE = 1'b0;
   logic         SYNC = 1'b0;
   logic [W-1:0] FREQ_WORD = 8'd0;
   logic         FREQ_VALID = 1'b0;
   logic         FREQ_READY, FREQ_ERR, CYCLE_PULSE, SAMPLE_PULSE;
   logic [S-1:0] SAMPLE_INDEX;
   logic [W-1:0] PHASE;

   int n_cmp = 0;
   int n_bad = 0;

   // expected {ready, err, cycle, sample, index, phase}
   logic [13:0] exp_q[$];

   int m_acc, m_inc, m_pend;
   bit m_pending, m_cp, m_sp, m_err;

   pmu_tick_generator #(.ACC_WIDTH(W), .SPC_LOG2(S), .DEFAULT_INC(DEF)) dut (
      .CLK(CLK), .nRST(nRST), .ENABLE(ENABLE), .SYNC(SYNC),
      .FREQ_WORD(FREQ_WORD), .FREQ_VALID(FREQ_VALID), .FREQ_READY(FREQ_READY),
      .FREQ_ERR(FREQ_ERR), .CYCLE_PULSE(CYCLE_PULSE), .SAMPLE_PULSE(SAMPLE_PULSE),
      .SAMPLE_INDEX(SAMPLE_INDEX), .PHASE(PHASE)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] model_vec();
      logic [7:0] ph;
      ph = 8'(m_acc);
      return {!m_pending, m_err, m_cp, m_sp, ph[7:6], ph};
   endfunction

   // advance the model with the current inputs, clock once, compare against it
   task automatic step();
      bit accept, ok;
      int s;
      accept = FREQ_VALID && !m_pending;
      ok     = (int'(FREQ_WORD) >= 1) && (int'(FREQ_WORD) <= MAX);
      m_err  = accept && !ok;
      if (SYNC) begin
         m_acc = 0;
         m_cp  = ENABLE;
         m_sp  = ENABLE;
         if (accept && ok) m_inc = int'(FREQ_WORD);
         else if (m_pending) m_inc = m_pend;
         m_pending = 1'b0;
      end else begin
         if (ENABLE) begin
            s    = m_acc + m_inc;
            m_cp = (s >= 256);
            m_sp = ((s % 256) / 64) != (m_acc / 64);
            m_acc = s % 256;
            if (m_pending && m_cp) begin
               m_inc     = m_pend;
               m_pending = 1'b0;
            end else if (accept && ok) begin
               m_pend    = int'(FREQ_WORD);
               m_pending = 1'b1;
            end
         end else begin
            m_cp = 1'b0;
            m_sp = 1'b0;
            if (accept && ok) begin
               m_pend    = int'(FREQ_WORD);
               m_pending = 1'b1;
            end
         end
      end
      exp_q.push_back(model_vec());
      @(posedge CLK);
      #1;
      check_val("cycle", {FREQ_READY, FREQ_ERR, CYCLE_PULSE, SAMPLE_PULSE, SAMPLE_INDEX, PHASE},
                exp_q.pop_front());
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic offer(input logic [7:0] w);
      FREQ_WORD  = w;
      FREQ_VALID = 1'b1;
      step();
      FREQ_VALID = 1'b0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #2;
      m_acc = 0; m_inc = DEF; m_pend = 0; m_pending = 1'b0;
      m_cp = 1'b0; m_sp = 1'b0; m_err = 1'b0;
      check_val("reset", {FREQ_READY, FREQ_ERR, CYCLE_PULSE, SAMPLE_PULSE, SAMPLE_INDEX, PHASE},
                {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0});
      nRST = 1'b1;
   endtask

   initial begin
      int cnt;
      @(posedge CLK);
      #1;
      do_reset();

      // default rate: sample every 4 edges, wrap every 16
      ENABLE = 1'b1;
      steps(4);
      check_val("edge4_idx", SAMPLE_INDEX, 2'd1);
      steps(12);
      check_val("edge16_cp", {CYCLE_PULSE, PHASE}, {1'b1, 8'd0});
      steps(16);

      // frequency change waits for the wrap
      steps(5);
      check_val("phase80", PHASE, 8'd80);
      offer(8'd32);
      check_val("ready_low", FREQ_READY, 1'b0);
      steps(10);
      check_val("wrap_ready", {CYCLE_PULSE, FREQ_READY}, {1'b1, 1'b1});
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         cnt += int'(CYCLE_PULSE);
      end
      check_val("fast_wraps", cnt, 2);

      // rejected words
      do_reset();
      offer(8'd64);
      check_val("err64", {FREQ_ERR, FREQ_READY}, {1'b1, 1'b1});
      offer(8'd0);
      check_val("err0", {FREQ_ERR, FREQ_READY}, {1'b1, 1'b1});
      steps(14);
      check_val("rej_period", {CYCLE_PULSE, PHASE}, {1'b1, 8'd0});

      // reach phase 100 with increment 4, then SYNC with a new word 16
      offer(8'd4);
      steps(15);
      steps(25);
      check_val("phase100", PHASE, 8'd100);
      SYNC = 1'b1;
      offer(8'd16);
      SYNC = 1'b0;
      check_val("sync", {CYCLE_PULSE, SAMPLE_PULSE, SAMPLE_INDEX, PHASE}, {1'b1, 1'b1, 2'd0, 8'd0});
      steps(15);
      check_val("sync_pre", CYCLE_PULSE, 1'b0);
      step();
      check_val("sync_next", CYCLE_PULSE, 1'b1);

      // hold while disabled
      steps(3);
      ENABLE = 1'b0;
      steps(10);
      check_val("hold48", {PHASE, CYCLE_PULSE, SAMPLE_PULSE}, {8'd48, 1'b0, 1'b0});
      ENABLE = 1'b1;
      steps(12);
      check_val("resume_pre", CYCLE_PULSE, 1'b0);
      step();
      check_val("resume_wrap", CYCLE_PULSE, 1'b1);

      // reset discards a pending word
      offer(8'd32);
      do_reset();
      ENABLE = 1'b1;
      steps(16);
      check_val("rst_period", {CYCLE_PULSE, PHASE}, {1'b1, 8'd0});

      // SYNC while disabled applies pending word with no pulses
      ENABLE = 1'b0;
      offer(8'd32);
      SYNC = 1'b1;
      step();
      SYNC = 1'b0;
      check_val("sync_dis", {CYCLE_PULSE, SAMPLE_PULSE, FREQ_READY}, {1'b0, 1'b0, 1'b1});
      ENABLE = 1'b1;
      steps(8);
      check_val("sync_dis_inc", {CYCLE_PULSE, PHASE}, {1'b1, 8'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
